// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared camera state encoding and default timing constants
package cam_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_OFF    = 3'd0,
        ST_PWDN   = 3'd1,
        ST_RST    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_CFG    = 3'd4,
        ST_READY  = 3'd5,
        ST_FAULT  = 3'd6
    } cam_state_t;

    // Default timings in xvclk cycles, shared with the SCCB engine and capture block
    localparam int DEF_T_PWDN_CYC      = 1190;
    localparam int DEF_T_RST_CYC       = 476;
    localparam int DEF_T_SETTLE_CYC    = 79968;
    localparam int DEF_CFG_TIMEOUT_CYC = 2000000;
    localparam int DEF_MAX_RETRY       = 3;
    localparam int DEF_CNT_W           = 32;

endpackage

// File: rtl/cam_delay_cnt.sv
// rtl/cam_delay_cnt.sv - clearable up-counter with terminal-count compare
module cam_delay_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             xvclk,
    input  logic             resetb,
    input  logic             clr,
    input  logic [CNT_W-1:0] term,
    output logic             hit
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Clearing loads zero so the first cycle of a new interval counts as cycle 0
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr) begin
            cnt_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge xvclk) begin
        if (resetb) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = (cnt_q == term);

endmodule

// File: rtl/cam_power_seq.sv
// rtl/cam_power_seq.sv - camera power-up/config sequencer; CAM_CFG_RETRY_EN enables config retries
module cam_power_seq
    import cam_pkg::*;
#(
    parameter int T_PWDN_CYC      = DEF_T_PWDN_CYC,
    parameter int T_RST_CYC       = DEF_T_RST_CYC,
    parameter int T_SETTLE_CYC    = DEF_T_SETTLE_CYC,
    parameter int CFG_TIMEOUT_CYC = DEF_CFG_TIMEOUT_CYC,
    parameter int MAX_RETRY       = DEF_MAX_RETRY,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic       xvclk,
    input  logic       resetb,
    input  logic       enable,
    output logic       cam_pwdn,
    output logic       cam_rst_n,
    output logic       cfg_start,
    input  logic       cfg_done,
    input  logic       cfg_err,
    output logic       cam_ready,
    output logic       fault,
    output logic       led,
    output logic [2:0] state_o,
    output logic [1:0] retry_cnt
);

    cam_state_t       state_d, state_q;
    logic [1:0]       retry_cnt_d, retry_cnt_q;
    logic             cam_pwdn_d, cam_pwdn_q;
    logic             cam_rst_n_d, cam_rst_n_q;
    logic             cfg_start_d, cfg_start_q;
    logic             cam_ready_d, cam_ready_q;
    logic             fault_d, fault_q;
    logic [CNT_W-1:0] term;
    logic             hit;
    logic             cfg_fail;

    cam_delay_cnt #(
        .CNT_W (CNT_W)
    ) u_delay_cnt (
        .xvclk  (xvclk),
        .resetb (resetb),
        .clr    (state_d != state_q),
        .term   (term),
        .hit    (hit)
    );

    // Terminal count for the interval belonging to the current state
    always_comb begin
        term = '0;
        case (state_q)
            ST_PWDN:   term = CNT_W'(T_PWDN_CYC - 1);
            ST_RST:    term = CNT_W'(T_RST_CYC - 1);
            ST_SETTLE: term = CNT_W'(T_SETTLE_CYC - 1);
            ST_CFG:    term = CNT_W'(CFG_TIMEOUT_CYC - 1);
            default:   term = '0;
        endcase
    end

    // Next state; an error beats a simultaneous done, a done on the last cycle beats the timeout
    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        cfg_fail    = cfg_err || (hit && !cfg_done);
        if (!enable) begin
            state_d     = ST_OFF;
            retry_cnt_d = 2'd0;
        end else begin
            case (state_q)
                ST_OFF:    state_d = ST_PWDN;
                ST_PWDN:   if (hit) state_d = ST_RST;
                ST_RST:    if (hit) state_d = ST_SETTLE;
                ST_SETTLE: if (hit) state_d = ST_CFG;
                ST_CFG: begin
                    if (cfg_fail) begin
`ifdef CAM_CFG_RETRY_EN
                        if (int'(retry_cnt_q) < MAX_RETRY) begin
                            retry_cnt_d = retry_cnt_q + 2'd1;
                            state_d     = ST_PWDN;
                        end else begin
                            state_d = ST_FAULT;
                        end
`else
                        state_d = ST_FAULT;
`endif
                    end else if (cfg_done) begin
                        state_d = ST_READY;
                    end
                end
                default:   state_d = state_q;
            endcase
        end
    end

    // Pin and status levels decoded from the next state so they register alongside it
    always_comb begin
        cam_pwdn_d  = (state_d == ST_OFF) || (state_d == ST_PWDN) || (state_d == ST_FAULT);
        cam_rst_n_d = (state_d == ST_SETTLE) || (state_d == ST_CFG) || (state_d == ST_READY);
        cfg_start_d = (state_d == ST_CFG);
        cam_ready_d = (state_d == ST_READY);
        fault_d     = (state_d == ST_FAULT);
    end

    // State, retry count and output registers
    always_ff @(posedge xvclk) begin
        if (resetb) begin
            state_q     <= ST_OFF;
            retry_cnt_q <= 2'd0;
            cam_pwdn_q  <= 1'b1;
            cam_rst_n_q <= 1'b0;
            cfg_start_q <= 1'b0;
            cam_ready_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            retry_cnt_q <= retry_cnt_d;
            cam_pwdn_q  <= cam_pwdn_d;
            cam_rst_n_q <= cam_rst_n_d;
            cfg_start_q <= cfg_start_d;
            cam_ready_q <= cam_ready_d;
            fault_q     <= fault_d;
        end
    end

    assign cam_pwdn  = cam_pwdn_q;
    assign cam_rst_n = cam_rst_n_q;
    assign cfg_start = cfg_start_q;
    assign cam_ready = cam_ready_q;
    assign led       = cam_ready_q;
    assign fault     = fault_q;
    assign state_o   = state_q;
    assign retry_cnt = retry_cnt_q;

    // Zero-length intervals would make a state last a full counter wrap
    param_nonzero: assert property (@(posedge xvclk)
        (T_PWDN_CYC > 0) && (T_RST_CYC > 0) && (T_SETTLE_CYC > 0) &&
        (CFG_TIMEOUT_CYC > 0) && (MAX_RETRY > 0) && (CNT_W > 0))
        else $error("cam_power_seq: zero-valued parameter");

endmodule

// File: tb/tb_cam_power_seq.sv
// tb/tb_cam_power_seq.sv - self-checking bench for cam_power_seq
module tb_cam_power_seq;

    localparam int TP = 10;
    localparam int TR = 5;
    localparam int TS = 20;
    localparam int TO = 50;
    localparam int MR = 2;

    logic       xvclk = 1'b0;
    logic       resetb = 1'b1;
    logic       enable = 1'b0;
    logic       cfg_done = 1'b0;
    logic       cfg_err = 1'b0;
    logic       cam_pwdn, cam_rst_n, cfg_start, cam_ready, fault, led;
    logic [2:0] state_o;
    logic [1:0] retry_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 xvclk = ~xvclk;

    cam_power_seq #(
        .T_PWDN_CYC      (TP),
        .T_RST_CYC       (TR),
        .T_SETTLE_CYC    (TS),
        .CFG_TIMEOUT_CYC (TO),
        .MAX_RETRY       (MR),
        .CNT_W           (32)
    ) dut (
        .xvclk     (xvclk),
        .resetb    (resetb),
        .enable    (enable),
        .cam_pwdn  (cam_pwdn),
        .cam_rst_n (cam_rst_n),
        .cfg_start (cfg_start),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .cam_ready (cam_ready),
        .fault     (fault),
        .led       (led),
        .state_o   (state_o),
        .retry_cnt (retry_cnt)
    );

    // Timeline model: a bring-up attempt is a start cycle plus elapsed time;
    // outcome 0 = in progress, 1 = configured, 2 = failed for good.
    bit m_act = 1'b0;
    int m_att = 0;
    int m_rtr = 0;
    int m_out = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    function automatic int exp_state();
        int e;
        if (!m_act) return 0;
        if (m_out == 1) return 5;
        if (m_out == 2) return 6;
        e = cyc - m_att;
        if (e < TP) return 1;
        if (e < TP + TR) return 2;
        if (e < TP + TR + TS) return 3;
        return 4;
    endfunction

    function automatic logic [10:0] exp_vec();
        int st;
        logic [2:0] s3;
        logic [1:0] r2;
        st = exp_state();
        s3 = st[2:0];
        r2 = m_rtr[1:0];
        return {s3, (st == 0 || st == 1 || st == 6), (st == 3 || st == 4 || st == 5),
                (st == 4), (st == 5), (st == 5), (st == 6), r2};
    endfunction

    function automatic logic [10:0] dut_vec();
        return {state_o, cam_pwdn, cam_rst_n, cfg_start, cam_ready, led, fault, retry_cnt};
    endfunction

    always @(posedge xvclk) begin
        int e;
        e = cyc - m_att;
        if (resetb || !enable) begin
            m_act = 1'b0;
            m_rtr = 0;
            m_out = 0;
        end else if (!m_act) begin
            m_act = 1'b1;
            m_att = cyc + 1;
            m_out = 0;
        end else if (m_out == 0 && e >= TP + TR + TS) begin
            if (cfg_err || (e - (TP + TR + TS) == TO - 1 && !cfg_done)) begin
`ifdef CAM_CFG_RETRY_EN
                if (m_rtr < MR) begin
                    m_rtr = m_rtr + 1;
                    m_att = cyc + 1;
                end else begin
                    m_out = 2;
                end
`else
                m_out = 2;
`endif
            end else if (cfg_done) begin
                m_out = 1;
            end
        end
        cyc = cyc + 1;
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge xvclk) begin
        if (chk_en) begin
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL model cyc=%0d: dut {st,pwdn,rstn,start,rdy,led,flt,rtr}=%b expected %b",
                         cyc, dut_vec(), exp_vec());
            end
        end
    end

    task automatic check(input string name, input int got, input int expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    // Counts consecutive negedges (starting now) spent in state st, bounded
    task automatic run_len(input logic [2:0] st, output int n);
        n = 0;
        while (state_o == st && n < 200) begin
            n++;
            @(negedge xvclk);
        end
    endtask

    task automatic bring_to_cfg();
        int n;
        run_len(3'd1, n);
        run_len(3'd2, n);
        run_len(3'd3, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [10:0] rst_vec;
        rst_vec = 11'b000_1_0_0_0_0_0_00;

        // Reset values
        resetb = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge xvclk);
        chk_en = 1'b1;
        check("reset_vec", int'(dut_vec()), int'(rst_vec));

        // Nominal bring-up
        resetb = 1'b0;
        enable = 1'b1;
        @(negedge xvclk);
        run_len(3'd1, n); check("nom_pwdn_len", n, 10);
        run_len(3'd2, n); check("nom_rst_len", n, 5);
        run_len(3'd3, n); check("nom_settle_len", n, 20);
        check("nom_cfg_start", int'(cfg_start), 1);
        repeat (7) @(negedge xvclk);
        cfg_done = 1'b1;
        @(negedge xvclk);
        cfg_done = 1'b0;
        check("nom_ready_state", int'(state_o), 5);
        check("nom_ready_led", int'({cam_ready, led, cfg_start}), 3'b110);
        cfg_err = 1'b1;
        @(negedge xvclk);
        cfg_err = 1'b0;
        @(negedge xvclk);
        check("ready_ignores_err", int'(state_o), 5);

        // Reset dominance from READY with enable held
        resetb = 1'b1;
        @(negedge xvclk);
        check("rst_dom_vec", int'(dut_vec()), int'(rst_vec));
        resetb = 1'b0;
        @(negedge xvclk);
        check("rst_restart_state", int'(state_o), 1);
        run_len(3'd1, n); check("rst_restart_pwdn_len", n, 10);

        // Abort during SETTLE cycle 8
        run_len(3'd2, n); check("abort_rst_len", n, 5);
        repeat (8) @(negedge xvclk);
        enable = 1'b0;
        @(negedge xvclk);
        check("abort_vec", int'({state_o, cam_pwdn, cam_rst_n, cfg_start}), 6'b000_1_0_0);
        enable = 1'b1;
        @(negedge xvclk);
        check("abort_restart_state", int'(state_o), 1);
        run_len(3'd1, n); check("abort_repwdn_len", n, 10);

        // Configuration timeout
        run_len(3'd2, n);
        run_len(3'd3, n);
        run_len(3'd4, n); check("timeout_len", n, 50);
`ifdef CAM_CFG_RETRY_EN
        check("timeout_retry_state", int'(state_o), 1);
        check("timeout_retry_cnt", int'(retry_cnt), 1);
`else
        check("timeout_fault_vec", int'({state_o, fault, cam_pwdn}), 5'b110_1_1);
        repeat (5) @(negedge xvclk);
        check("fault_hold", int'(state_o), 6);
`endif
        enable = 1'b0;
        @(negedge xvclk);
        check("fault_clear", int'({state_o, fault}), 4'b000_0);

        // Simultaneous done and error
        enable = 1'b1;
        @(negedge xvclk);
        bring_to_cfg();
        repeat (3) @(negedge xvclk);
        cfg_done = 1'b1;
        cfg_err = 1'b1;
        @(negedge xvclk);
        cfg_done = 1'b0;
        cfg_err = 1'b0;
`ifdef CAM_CFG_RETRY_EN
        check("simul_state", int'(state_o), 1);
`else
        check("simul_state", int'(state_o), 6);
`endif
        check("simul_not_ready", int'(cam_ready), 0);
        enable = 1'b0;
        @(negedge xvclk);

`ifdef CAM_CFG_RETRY_EN
        // Three failing attempts: two retries, then FAULT
        enable = 1'b1;
        @(negedge xvclk);
        bring_to_cfg();
        for (int a = 1; a <= 3; a++) begin
            repeat (2) @(negedge xvclk);
            cfg_err = 1'b1;
            @(negedge xvclk);
            cfg_err = 1'b0;
            if (a < 3) begin
                check("retry_cnt_step", int'(retry_cnt), a);
                run_len(3'd1, n); check("retry_pwdn_len", n, 10);
                run_len(3'd2, n); check("retry_rst_len", n, 5);
                run_len(3'd3, n); check("retry_settle_len", n, 20);
            end else begin
                check("retry_final_vec", int'({state_o, fault, cam_pwdn, retry_cnt}), 7'b110_1_1_10);
            end
        end
        enable = 1'b0;
        @(negedge xvclk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
